// File: rtl/vx_axi_write_decoupler.sv
// Splits a combined single-beat write request into independent AXI AW and W
// handshakes, tracks outstanding writes, and passes B responses straight through.
module vx_axi_write_decoupler #(
  parameter int unsigned AXI_DATA_WIDTH = 512,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_TID_WIDTH  = 8,
  parameter int unsigned MAX_PENDING    = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic [AXI_ADDR_WIDTH-1:0]            req_addr,
  input  logic [AXI_TID_WIDTH-1:0]             req_id,
  input  logic [AXI_DATA_WIDTH-1:0]            req_data,
  input  logic [AXI_DATA_WIDTH/8-1:0]          req_strb,
  output logic                                 m_axi_awvalid,
  input  logic                                 m_axi_awready,
  output logic [AXI_ADDR_WIDTH-1:0]            m_axi_awaddr,
  output logic [AXI_TID_WIDTH-1:0]             m_axi_awid,
  output logic [7:0]                           m_axi_awlen,
  output logic [2:0]                           m_axi_awsize,
  output logic [1:0]                           m_axi_awburst,
  output logic                                 m_axi_wvalid,
  input  logic                                 m_axi_wready,
  output logic [AXI_DATA_WIDTH-1:0]            m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]          m_axi_wstrb,
  output logic                                 m_axi_wlast,
  input  logic                                 m_axi_bvalid,
  output logic                                 m_axi_bready,
  input  logic [AXI_TID_WIDTH-1:0]             m_axi_bid,
  input  logic [1:0]                           m_axi_bresp,
  output logic                                 rsp_valid,
  input  logic                                 rsp_ready,
  output logic [AXI_TID_WIDTH-1:0]             rsp_id,
  output logic [1:0]                           rsp_resp,
  output logic [$clog2(MAX_PENDING+1)-1:0]     pending_count
);

  localparam int unsigned CNT_W = $clog2(MAX_PENDING + 1);

  logic aw_done;
  logic w_done;
  logic start_ok;
  logic aw_fire;
  logic w_fire;
  logic req_fire;
  logic b_fire;

  // A request already in progress may always finish; only fresh starts are throttled.
  assign start_ok = ~reset & (aw_done | w_done | (pending_count < CNT_W'(MAX_PENDING)));

  assign m_axi_awvalid = req_valid & ~aw_done & start_ok;
  assign m_axi_wvalid  = req_valid & ~w_done & start_ok;
  assign req_ready     = start_ok & (aw_done | m_axi_awready) & (w_done | m_axi_wready);

  assign aw_fire  = m_axi_awvalid & m_axi_awready;
  assign w_fire   = m_axi_wvalid & m_axi_wready;
  assign req_fire = req_valid & req_ready;
  assign b_fire   = m_axi_bvalid & m_axi_bready;

  assign m_axi_awaddr  = req_addr;
  assign m_axi_awid    = req_id;
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = 3'($clog2(AXI_DATA_WIDTH / 8));
  assign m_axi_awburst = 2'b01;
  assign m_axi_wdata   = req_data;
  assign m_axi_wstrb   = req_strb;
  assign m_axi_wlast   = 1'b1;

  assign rsp_valid    = m_axi_bvalid;
  assign m_axi_bready = rsp_ready;
  assign rsp_id       = m_axi_bid;
  assign rsp_resp     = m_axi_bresp;

  // Channel-done flags and outstanding-write counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      pending_count <= '0;
    end else begin
      if (req_fire) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_fire) aw_done <= 1'b1;
        if (w_fire)  w_done  <= 1'b1;
      end
      if (req_fire && !b_fire) begin
        pending_count <= pending_count + CNT_W'(1);
      end else if (b_fire && !req_fire && (pending_count != '0)) begin
        pending_count <= pending_count - CNT_W'(1);
      end
    end
  end

  // A B response with nothing outstanding indicates a protocol error downstream.
  assert property (@(posedge clk) disable iff (reset) b_fire |-> (pending_count != '0));

endmodule

// File: tb/tb_vx_axi_write_decoupler.sv
// Scoreboard bench: expected AW/W/B traffic is queued by the stimulus and
// popped by a negedge monitor whenever a handshake occurs.
module tb_vx_axi_write_decoupler;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 32;
  localparam int unsigned TW  = 8;
  localparam int unsigned MP  = 4;
  localparam int unsigned CW  = $clog2(MP + 1);

  logic            clk = 1'b0;
  logic            reset;
  logic            req_valid;
  logic            req_ready;
  logic [AW-1:0]   req_addr;
  logic [TW-1:0]   req_id;
  logic [DW-1:0]   req_data;
  logic [DW/8-1:0] req_strb;
  logic            m_axi_awvalid;
  logic            m_axi_awready;
  logic [AW-1:0]   m_axi_awaddr;
  logic [TW-1:0]   m_axi_awid;
  logic [7:0]      m_axi_awlen;
  logic [2:0]      m_axi_awsize;
  logic [1:0]      m_axi_awburst;
  logic            m_axi_wvalid;
  logic            m_axi_wready;
  logic [DW-1:0]   m_axi_wdata;
  logic [DW/8-1:0] m_axi_wstrb;
  logic            m_axi_wlast;
  logic            m_axi_bvalid;
  logic            m_axi_bready;
  logic [TW-1:0]   m_axi_bid;
  logic [1:0]      m_axi_bresp;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [TW-1:0]   rsp_id;
  logic [1:0]      rsp_resp;
  logic [CW-1:0]   pending_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW+TW-1:0]   aw_q[$];
  logic [DW+DW/8-1:0] w_q[$];
  logic [TW+2-1:0]    rsp_q[$];

  vx_axi_write_decoupler #(
    .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .AXI_TID_WIDTH(TW), .MAX_PENDING(MP)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_id(req_id), .req_data(req_data), .req_strb(req_strb),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awid(m_axi_awid), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_resp(rsp_resp),
    .pending_count(pending_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Offer a request and queue its expected AW and/or W beats.
  task automatic offer(input logic [AW-1:0] a, input logic [TW-1:0] id,
                       input logic [DW-1:0] d, input logic [DW/8-1:0] s,
                       input bit exp_aw, input bit exp_w);
    req_valid = 1'b1;
    req_addr  = a;
    req_id    = id;
    req_data  = d;
    req_strb  = s;
    if (exp_aw) aw_q.push_back({a, id});
    if (exp_w)  w_q.push_back({d, s});
  endtask

  task automatic ctrl(input logic av, input logic wv, input logic rr, input logic [CW-1:0] pc,
                      input string tag);
    check({tag, "_awvalid"}, 64'(m_axi_awvalid), 64'(av));
    check({tag, "_wvalid"}, 64'(m_axi_wvalid), 64'(wv));
    check({tag, "_req_ready"}, 64'(req_ready), 64'(rr));
    check({tag, "_pending"}, 64'(pending_count), 64'(pc));
  endtask

  // Monitor: pop and compare whenever the DUT completes a handshake.
  always @(negedge clk) begin
    logic [AW+TW-1:0]   ea;
    logic [DW+DW/8-1:0] ew;
    logic [TW+2-1:0]    er;
    if (m_axi_awvalid && m_axi_awready) begin
      if (aw_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL aw_unexpected: got addr 0x%0h id 0x%0h, expected no AW (t=%0t)",
                 m_axi_awaddr, m_axi_awid, $time);
      end else begin
        ea = aw_q.pop_front();
        check("aw_addr_id", 64'({m_axi_awaddr, m_axi_awid}), 64'(ea));
        check("aw_const", 64'({m_axi_awlen, m_axi_awsize, m_axi_awburst}),
              64'({8'd0, 3'd2, 2'b01}));
      end
    end
    if (m_axi_wvalid && m_axi_wready) begin
      if (w_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL w_unexpected: got data 0x%0h, expected no W (t=%0t)", m_axi_wdata, $time);
      end else begin
        ew = w_q.pop_front();
        check("w_data_strb", 64'({m_axi_wdata, m_axi_wstrb}), 64'(ew));
        check("w_last", 64'(m_axi_wlast), 64'(1));
      end
    end
    if (rsp_valid && rsp_ready) begin
      if (rsp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL rsp_unexpected: got id 0x%0h, expected no response (t=%0t)", rsp_id, $time);
      end else begin
        er = rsp_q.pop_front();
        check("rsp_id_resp", 64'({rsp_id, rsp_resp}), 64'(er));
        check("b_ready", 64'(m_axi_bready), 64'(1));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b1; req_addr = '0; req_id = '0; req_data = '0; req_strb = '0;
    m_axi_awready = 1'b1; m_axi_wready = 1'b1;
    m_axi_bvalid = 1'b0; m_axi_bid = '0; m_axi_bresp = '0; rsp_ready = 1'b1;

    // Reset cycle: no valids, not ready, even with a request pending.
    sample(); ctrl(1'b0, 1'b0, 1'b0, CW'(0), "rst");
    step(); reset = 1'b0; req_valid = 1'b0;
    sample(); check("post_rst_pending", 64'(pending_count), 64'(0));

    // Both channels ready: accepted in one cycle.
    step(); offer(32'h0000_1000, 8'h11, 32'hA5A5_0001, 4'hF, 1'b1, 1'b1);
    sample(); ctrl(1'b1, 1'b1, 1'b1, CW'(0), "both");
    step(); req_valid = 1'b0;
    sample(); check("both_pending", 64'(pending_count), 64'(1));

    // Request fire and B fire together leave the count unchanged.
    step(); offer(32'h0000_3000, 8'h33, 32'h1234_5678, 4'h3, 1'b1, 1'b1);
    m_axi_bvalid = 1'b1; m_axi_bid = 8'h5A; m_axi_bresp = 2'd2; rsp_q.push_back({8'h5A, 2'd2});
    sample(); ctrl(1'b1, 1'b1, 1'b1, CW'(1), "same");
    step(); req_valid = 1'b0; m_axi_bvalid = 1'b0;
    sample(); check("same_pending", 64'(pending_count), 64'(1));

    // AW accepted early, W stalled: AW must not be reissued.
    step(); offer(32'h0000_2000, 8'h22, 32'hDEAD_BEEF, 4'hC, 1'b1, 1'b1); m_axi_wready = 1'b0;
    sample(); ctrl(1'b1, 1'b1, 1'b0, CW'(1), "wstall0");
    for (int i = 1; i <= 2; i++) begin
      step(); sample(); ctrl(1'b0, 1'b1, 1'b0, CW'(1), "wstall");
    end
    step(); m_axi_wready = 1'b1;
    sample(); ctrl(1'b0, 1'b1, 1'b1, CW'(1), "wstall3");
    step(); req_valid = 1'b0;
    sample(); check("wstall_pending", 64'(pending_count), 64'(2));

    // Fill to the pending limit, then the next start is blocked until a B.
    step(); offer(32'h0000_4000, 8'h44, 32'h0000_0044, 4'h1, 1'b1, 1'b1);
    sample(); ctrl(1'b1, 1'b1, 1'b1, CW'(2), "fill0");
    step(); offer(32'h0000_5000, 8'h55, 32'h0000_0055, 4'h2, 1'b1, 1'b1);
    sample(); ctrl(1'b1, 1'b1, 1'b1, CW'(3), "fill1");
    step(); req_valid = 1'b1; req_addr = 32'h0000_6000; req_id = 8'h66;
    req_data = 32'h0000_0066; req_strb = 4'h4;
    sample(); ctrl(1'b0, 1'b0, 1'b0, CW'(4), "full");
    step(); m_axi_bvalid = 1'b1; m_axi_bid = 8'h01; m_axi_bresp = 2'd0; rsp_q.push_back({8'h01, 2'd0});
    sample(); ctrl(1'b0, 1'b0, 1'b0, CW'(4), "full_b");
    step(); m_axi_bvalid = 1'b0;
    offer(32'h0000_6000, 8'h66, 32'h0000_0066, 4'h4, 1'b1, 1'b1);
    sample(); ctrl(1'b1, 1'b1, 1'b1, CW'(3), "unblock");
    step(); req_valid = 1'b0;
    sample(); check("unblock_pending", 64'(pending_count), 64'(4));

    // Drain one, start a partial (W only), then reset mid-request.
    step(); m_axi_bvalid = 1'b1; m_axi_bid = 8'h02; m_axi_bresp = 2'd1; rsp_q.push_back({8'h02, 2'd1});
    step(); m_axi_bvalid = 1'b0; m_axi_awready = 1'b0;
    offer(32'h0000_7000, 8'h77, 32'h0000_0077, 4'h8, 1'b0, 1'b1);
    sample(); ctrl(1'b1, 1'b1, 1'b0, CW'(3), "partial0");
    step(); sample(); ctrl(1'b1, 1'b0, 1'b0, CW'(3), "partial1");
    step(); reset = 1'b1;
    sample(); ctrl(1'b0, 1'b0, 1'b0, CW'(3), "midrst");
    step(); reset = 1'b0; m_axi_awready = 1'b1;
    offer(32'h0000_8000, 8'h88, 32'h0000_0088, 4'hF, 1'b1, 1'b1);
    sample(); ctrl(1'b1, 1'b1, 1'b1, CW'(0), "after_rst");
    step(); req_valid = 1'b0;
    sample(); check("after_rst_pending", 64'(pending_count), 64'(1));

    step(); step();
    check("aw_q_empty", 64'(aw_q.size()), 64'(0));
    check("w_q_empty", 64'(w_q.size()), 64'(0));
    check("rsp_q_empty", 64'(rsp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
